// File: rtl/memory_pkg.sv
// memory_pkg: shared definitions for the unified instruction/data memory.
//   access_size_t      2-bit access-size code carried on the access_size port
//   SZ_BYTE/HALF/WORD  size encodings (2'b11 is reserved and behaves as a word)
//   DEFAULT_BASE_ADDR  first byte address served by the memory
//   align_lane()       forces the low offset bits to the natural alignment of a size
package memory_pkg;

  typedef logic [1:0] access_size_t;

  localparam access_size_t SZ_BYTE = 2'b00;
  localparam access_size_t SZ_HALF = 2'b01;
  localparam access_size_t SZ_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

  // Byte lane (offset[1:0]) of the first, most significant byte of an access.
  // Halfwords drop bit 0, words (and the reserved code) drop both bits.
  function automatic logic [1:0] align_lane(input logic [1:0] lane, input access_size_t sz);
    case (sz)
      SZ_BYTE: return lane;
      SZ_HALF: return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_steer.sv
// mem_byte_steer: combinational big-endian lane steering for the memory.
//   lane         in  offset[1:0] of the access (alignment is applied here)
//   access_size  in  byte / half / word (reserved code treated as word)
//   data_in      in  right-justified write data
//   rd_bytes     in  the four bytes of the addressed word, [0] = lowest address
//   wr_en        out per-lane write enables, [0] = lowest address
//   wr_bytes     out per-lane write data, [0] = lowest address
//   rd_data      out zero-extended read value, lowest address in the MSB
module mem_byte_steer
  import memory_pkg::*;
(
  input  logic [1:0]       lane,
  input  access_size_t     access_size,
  input  logic [31:0]      data_in,
  input  logic [3:0][7:0]  rd_bytes,
  output logic [3:0]       wr_en,
  output logic [3:0][7:0]  wr_bytes,
  output logic [31:0]      rd_data
);

  logic [1:0] first;
  logic [1:0] second;

  always_comb begin
    first    = align_lane(lane, access_size);
    // For a halfword the first lane is 0 or 2, so its partner is first | 1.
    second   = {first[1], 1'b1};
    wr_en    = '0;
    wr_bytes = '0;
    rd_data  = '0;
    case (access_size)
      SZ_BYTE: begin
        wr_en[first]    = 1'b1;
        wr_bytes[first] = data_in[7:0];
        rd_data         = {24'b0, rd_bytes[first]};
      end
      SZ_HALF: begin
        wr_en[first]     = 1'b1;
        wr_en[second]    = 1'b1;
        wr_bytes[first]  = data_in[15:8];
        wr_bytes[second] = data_in[7:0];
        rd_data          = {16'b0, rd_bytes[first], rd_bytes[second]};
      end
      default: begin
        wr_en       = 4'b1111;
        wr_bytes[0] = data_in[31:24];
        wr_bytes[1] = data_in[23:16];
        wr_bytes[2] = data_in[15:8];
        wr_bytes[3] = data_in[7:0];
        rd_data     = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
      end
    endcase
  end

endmodule

// File: rtl/memory.sv
// memory: byte-addressed, big-endian unified instruction/data memory.
//   clk          in  single clock, all state updates on the rising edge
//   rst_n        in  asynchronous active-low reset (clears data_out only)
//   address      in  byte address; BASE_ADDR maps to array byte 0
//   data_in      in  right-justified write data
//   write        in  1 = write cycle, 0 = read cycle
//   access_size  in  00 byte, 01 half, 10 word, 11 treated as word
//   data_out     out registered, zero-extended read data (one-cycle latency)
// There is no handshake: every clock cycle is one access, either a read or a
// write, and inputs are expected stable ahead of the rising edge.
// The array starts at zero.
module memory
  import memory_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_BYTES = 1048576,
  parameter              INIT_FILE   = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  address,
  input  logic [31:0]  data_in,
  input  logic         write,
  input  access_size_t access_size,
  output logic [31:0]  data_out
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // 2-state storage so never-written bytes read back as 8'h00.
  bit [7:0] mem [DEPTH_BYTES];

  logic [31:0]      off;
  logic             in_range;
  logic [AW-1:0]    word_base;
  logic [3:0][7:0]  rd_bytes;
  logic [3:0]       wr_en;
  logic [3:0][7:0]  wr_bytes;
  logic [31:0]      rd_data;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign off       = address - BASE_ADDR;
  assign in_range  = off < 32'(DEPTH_BYTES);
  assign word_base = off[AW-1:0] & ~AW'(3);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_bytes[i] = mem[word_base | AW'(i)];
    end
  end

  mem_byte_steer u_steer (
    .lane        (off[1:0]),
    .access_size (access_size),
    .data_in     (data_in),
    .rd_bytes    (rd_bytes),
    .wr_en       (wr_en),
    .wr_bytes    (wr_bytes),
    .rd_data     (rd_data)
  );

  // The array is not reset, but a write sampled while rst_n is low is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) mem[word_base | AW'(i)] <= wr_bytes[i];
      end
    end
  end

  // Write cycles hold the previous read value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (!write) begin
      data_out <= in_range ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed and light random checks of the memory block.
module tb_memory;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam int unsigned DEPTH = 1048576;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write;
  logic [1:0]  access_size;
  logic [31:0] data_out;

  logic [31:0] exp_q[$];
  logic [31:0] last_out;
  int          n_cmp;
  int          n_err;

  memory #(
    .BASE_ADDR   (BASE),
    .DEPTH_BYTES (DEPTH),
    .INIT_FILE   ("")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address     (address),
    .data_in     (data_in),
    .write       (write),
    .access_size (access_size),
    .data_out    (data_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare: pop the oldest expectation and check the observation.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Driver: one access per cycle. Writes expect data_out to hold.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [1:0] sz, input logic [31:0] rd_exp);
    logic [31:0] e;
    address     = a;
    data_in     = d;
    write       = w;
    access_size = sz;
    e           = w ? last_out : rd_exp;
    last_out    = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, data_out);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] addr;
    int          lane;
    n_cmp       = 0;
    n_err       = 0;
    last_out    = '0;
    rst_n       = 1'b0;
    address     = '0;
    data_in     = '0;
    write       = 1'b0;
    access_size = 2'b00;

    #2;
    exp_q.push_back(32'h0);
    check("reset_state", data_out);
    #10;
    rst_n = 1'b1;

    // Word write / sub-word reads
    step("wr_word",    BASE,     32'h9876_5432, 1'b1, 2'b10, 32'h0);
    step("rd_word",    BASE,     32'h0,         1'b0, 2'b10, 32'h9876_5432);
    step("rd_half",    BASE,     32'h0,         1'b0, 2'b01, 32'h0000_9876);
    step("rd_byte",    BASE,     32'h0,         1'b0, 2'b00, 32'h0000_0098);
    step("rd_byte3",   BASE + 3, 32'h0,         1'b0, 2'b00, 32'h0000_0032);
    step("rd_half2",   BASE + 2, 32'h0,         1'b0, 2'b01, 32'h0000_5432);
    step("rd_half_mis", BASE + 3, 32'h0,        1'b0, 2'b01, 32'h0000_5432);
    step("rd_rsvd",    BASE + 1, 32'h0,         1'b0, 2'b11, 32'h9876_5432);

    // Halfword write
    step("wr_half",    BASE + 8, 32'h0000_AAAA, 1'b1, 2'b01, 32'h0);
    step("rd_half8",   BASE + 8, 32'h0,         1'b0, 2'b01, 32'h0000_AAAA);
    step("rd_word8",   BASE + 8, 32'h0,         1'b0, 2'b10, 32'hAAAA_0000);

    // Byte write
    step("wr_byte",    BASE + 12, 32'h0000_00BB, 1'b1, 2'b00, 32'h0);
    step("rd_byteC",   BASE + 12, 32'h0,         1'b0, 2'b00, 32'h0000_00BB);
    step("rd_wordC",   BASE + 12, 32'h0,         1'b0, 2'b10, 32'hBB00_0000);

    // Range boundaries
    step("wr_below",   32'h8001_FFFC, 32'h1234_5678, 1'b1, 2'b10, 32'h0);
    step("wr_above",   BASE + DEPTH,  32'h1234_5678, 1'b1, 2'b10, 32'h0);
    step("rd_below",   32'h8001_FFFC, 32'h0,         1'b0, 2'b10, 32'h0);
    step("rd_above",   BASE + DEPTH,  32'h0,         1'b0, 2'b10, 32'h0);
    step("rd_base_ok", BASE,          32'h0,         1'b0, 2'b10, 32'h9876_5432);
    step("wr_last",    BASE + DEPTH - 1, 32'h0000_005A, 1'b1, 2'b00, 32'h0);
    step("rd_last",    BASE + DEPTH - 1, 32'h0,         1'b0, 2'b00, 32'h0000_005A);
    step("rd_lastw",   BASE + DEPTH - 4, 32'h0,         1'b0, 2'b10, 32'h0000_005A);
    step("rd_base_ok2", BASE,         32'h0,         1'b0, 2'b10, 32'h9876_5432);

    // Asynchronous reset between edges, with a write held across an edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    check("rst_async", data_out);
    address     = BASE;
    data_in     = 32'hDEAD_BEEF;
    write       = 1'b1;
    access_size = 2'b10;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    check("rst_hold", data_out);
    @(negedge clk);
    rst_n    = 1'b1;
    write    = 1'b0;
    last_out = 32'h0;
    step("rd_after_rst", BASE, 32'h0, 1'b0, 2'b10, 32'h9876_5432);

    // Random word writes, read back through a random byte and halfword
    for (int k = 0; k < 6; k++) begin
      rnd  = $urandom;
      addr = BASE + 32'h100 + 32'(4 * k);
      lane = $urandom_range(0, 3);
      step("rnd_wr",   addr, rnd, 1'b1, 2'b10, 32'h0);
      step("rnd_word", addr, 32'h0, 1'b0, 2'b10, rnd);
      step("rnd_byte", addr + 32'(lane), 32'h0, 1'b0, 2'b00,
           {24'b0, rnd[31 - 8 * lane -: 8]});
      step("rnd_half", addr + 32'(lane), 32'h0, 1'b0, 2'b01,
           (lane < 2) ? {16'b0, rnd[31:16]} : {16'b0, rnd[15:0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
